// File: rtl/msix_pkg.sv
// Shared MSI-X scheduling types: vector index width, scheduler states, pointer helper.
package msix_pkg;

  localparam int unsigned MSIX_MAX_VECTORS = 2048;
  localparam int unsigned MSIX_VEC_W       = 11;

  typedef logic [MSIX_VEC_W-1:0] vec_idx_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_ACK = 2'd1,
    DONE     = 2'd2
  } sched_state_e;

  // Advance a round-robin pointer modulo n (n >= 1).
  function automatic vec_idx_t wrap_inc(vec_idx_t idx, int unsigned n);
    if (32'(idx) + 32'd1 >= n) begin
      return '0;
    end
    return idx + vec_idx_t'(1);
  endfunction

endpackage

// File: rtl/msix_vector_scheduler_if.sv
// Single-outstanding MSI-X message handshake between the scheduler and the PCIe core.
interface msix_vector_scheduler_if #(
  parameter int unsigned VEC_W = 11
);

  logic             msix_interrupt;
  logic [VEC_W-1:0] msix_vector;
  logic             msix_interrupt_ack;

  modport master (
    output msix_interrupt,
    output msix_vector,
    input  msix_interrupt_ack
  );

  modport slave (
    input  msix_interrupt,
    input  msix_vector,
    output msix_interrupt_ack
  );

endinterface

// File: rtl/msix_rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or above ptr_i, wrapping,
// found by a priority search over the request vector concatenated with itself.
module msix_rr_arbiter #(
  parameter int unsigned NUM_VECTORS = 32,
  parameter int unsigned VEC_W       = 11
) (
  input  logic [NUM_VECTORS-1:0] req_i,
  input  logic [VEC_W-1:0]       ptr_i,
  output logic                   grant_valid_o,
  output logic [VEC_W-1:0]       grant_o
);

  logic [2*NUM_VECTORS-1:0] dbl_req;
  logic                     found;
  logic [VEC_W-1:0]         grant_idx;

  assign dbl_req = {req_i, req_i};

  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    for (int unsigned i = 0; i < 2 * NUM_VECTORS; i++) begin
      if (!found && (i >= 32'(ptr_i)) && dbl_req[i]) begin
        found     = 1'b1;
        grant_idx = (i >= NUM_VECTORS) ? VEC_W'(i - NUM_VECTORS) : VEC_W'(i);
      end
    end
  end

  assign grant_valid_o = found;
  assign grant_o       = grant_idx;

endmodule

// File: rtl/msix_vector_scheduler.sv
// MSI-X vector scheduler: latches per-vector requests into the PBA and delivers one
// eligible vector at a time, round-robin. Optional ack timeout: MSIX_SCHED_TIMEOUT_EN.
module msix_vector_scheduler
  import msix_pkg::*;
#(
  parameter int unsigned NUM_VECTORS = 32,
  parameter int unsigned VEC_W       = 11,
  parameter int unsigned ACK_TIMEOUT = 1023
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   msix_enable,
  input  logic                   msix_function_mask,
  input  logic [NUM_VECTORS-1:0] vec_req,
  input  logic [NUM_VECTORS-1:0] vec_mask,
  output logic [NUM_VECTORS-1:0] pba_pending,
  msix_vector_scheduler_if.master msix_io,
`ifdef MSIX_SCHED_TIMEOUT_EN
  output logic                   timeout_err,
`endif
  output logic                   sched_busy
);

  if (NUM_VECTORS < 1 || NUM_VECTORS > MSIX_MAX_VECTORS || VEC_W != MSIX_VEC_W ||
      ACK_TIMEOUT < 1) begin : gen_param_check
    $error("msix_vector_scheduler: illegal parameterisation");
  end

  sched_state_e           state_q, state_d;
  logic                   irq_q, irq_d;
  vec_idx_t               vec_q, vec_d;
  vec_idx_t               rr_ptr_q, rr_ptr_d;
  logic [NUM_VECTORS-1:0] pending_q, pending_d;
  logic [NUM_VECTORS-1:0] eligible;
  logic [NUM_VECTORS-1:0] clr_mask;
  logic                   clr_req;
  logic                   grant_valid;
  vec_idx_t               grant;

`ifdef MSIX_SCHED_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(ACK_TIMEOUT + 1);
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            terr_q, terr_d;
`endif

  assign eligible = pending_q & ~vec_mask &
                    {NUM_VECTORS{msix_enable & ~msix_function_mask}};

  msix_rr_arbiter #(
    .NUM_VECTORS (NUM_VECTORS),
    .VEC_W       (MSIX_VEC_W)
  ) u_arb (
    .req_i         (eligible),
    .ptr_i         (rr_ptr_q),
    .grant_valid_o (grant_valid),
    .grant_o       (grant)
  );

  always_comb begin
    state_d  = state_q;
    irq_d    = irq_q;
    vec_d    = vec_q;
    rr_ptr_d = rr_ptr_q;
    clr_req  = 1'b0;
`ifdef MSIX_SCHED_TIMEOUT_EN
    cnt_d    = cnt_q;
    terr_d   = terr_q;
`endif
    if (!msix_enable) begin
      // Disable aborts any in-flight message; rr_ptr is deliberately retained.
      state_d = IDLE;
      irq_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (grant_valid) begin
            state_d = WAIT_ACK;
            irq_d   = 1'b1;
            vec_d   = grant;
`ifdef MSIX_SCHED_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end
        end
        WAIT_ACK: begin
          if (msix_io.msix_interrupt_ack) begin
            state_d  = DONE;
            irq_d    = 1'b0;
            clr_req  = 1'b1;
            rr_ptr_d = wrap_inc(vec_q, NUM_VECTORS);
          end
`ifdef MSIX_SCHED_TIMEOUT_EN
          // Give up on the core but keep the vector pending for a later retry.
          else if (32'(cnt_q) + 32'd1 == ACK_TIMEOUT) begin
            state_d  = DONE;
            irq_d    = 1'b0;
            rr_ptr_d = wrap_inc(vec_q, NUM_VECTORS);
            terr_d   = 1'b1;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
`endif
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // A request at the ack edge wins over the clear of the same vector.
  always_comb begin
    clr_mask = '0;
    for (int unsigned i = 0; i < NUM_VECTORS; i++) begin
      clr_mask[i] = clr_req && (32'(vec_q) == i);
    end
    pending_d = msix_enable ? ((pending_q & ~clr_mask) | vec_req) : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      irq_q     <= 1'b0;
      vec_q     <= '0;
      rr_ptr_q  <= '0;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      irq_q     <= irq_d;
      vec_q     <= vec_d;
      rr_ptr_q  <= rr_ptr_d;
      pending_q <= pending_d;
    end
  end

`ifdef MSIX_SCHED_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      terr_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      terr_q <= terr_d;
    end
  end

  assign timeout_err = terr_q;
`endif

  assign pba_pending            = pending_q;
  assign msix_io.msix_interrupt = irq_q;
  assign msix_io.msix_vector    = VEC_W'(vec_q);
  assign sched_busy             = (state_q != IDLE);

endmodule

// File: tb/tb_msix_vector_scheduler.sv
// Directed bench for msix_vector_scheduler: expected vectors are queued as requests are
// driven and popped when the DUT raises msix_interrupt.
module tb_msix_vector_scheduler;

  localparam int unsigned NV = 32;
`ifdef MSIX_SCHED_TIMEOUT_EN
  localparam int unsigned AckTo = 15;
`else
  localparam int unsigned AckTo = 1023;
`endif

  logic          clk;
  logic          reset;
  logic          msix_enable;
  logic          msix_function_mask;
  logic [NV-1:0] vec_req;
  logic [NV-1:0] vec_mask;
  logic [NV-1:0] pba_pending;
  logic          sched_busy;
`ifdef MSIX_SCHED_TIMEOUT_EN
  logic          timeout_err;
`endif

  msix_vector_scheduler_if #(.VEC_W(11)) bus ();

  msix_vector_scheduler #(
    .NUM_VECTORS (NV),
    .VEC_W       (11),
    .ACK_TIMEOUT (AckTo)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .msix_enable        (msix_enable),
    .msix_function_mask (msix_function_mask),
    .vec_req            (vec_req),
    .vec_mask           (vec_mask),
    .pba_pending        (pba_pending),
    .msix_io            (bus),
`ifdef MSIX_SCHED_TIMEOUT_EN
    .timeout_err        (timeout_err),
`endif
    .sched_busy         (sched_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int unsigned  errors = 0;
  int unsigned  checks = 0;
  int unsigned  sb[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic pulse(input logic [NV-1:0] bits);
    vec_req = bits;
    tick();
    vec_req = '0;
  endtask

  // Wait (bounded) for msix_interrupt, then pop the scoreboard and compare the vector.
  task automatic expect_irq(input string tag, input int budget);
    int          n;
    int unsigned exp;
    n = 0;
    while (!bus.msix_interrupt && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_irq"}, 32'(bus.msix_interrupt), 32'd1);
    exp = (sb.size() > 0) ? sb.pop_front() : 32'hffff_ffff;
    check({tag, "_vec"}, 32'(bus.msix_vector), exp);
  endtask

  task automatic do_ack(input string tag);
    bus.msix_interrupt_ack = 1'b1;
    tick();
    bus.msix_interrupt_ack = 1'b0;
    check({tag, "_irq_drop"}, 32'(bus.msix_interrupt), 32'd0);
  endtask

  task automatic quiet(input string tag, input int cycles);
    int hits;
    hits = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (bus.msix_interrupt) hits++;
    end
    check({tag, "_no_irq"}, 32'(hits), 32'd0);
  endtask

  initial begin
    reset                  = 1'b1;
    msix_enable            = 1'b1;
    msix_function_mask     = 1'b0;
    vec_req                = '0;
    vec_mask               = '0;
    bus.msix_interrupt_ack = 1'b0;
    tick();
    tick();
    check("rst_pba", pba_pending, 32'd0);
    check("rst_irq", 32'(bus.msix_interrupt), 32'd0);
    check("rst_vec", 32'(bus.msix_vector), 32'd0);
    check("rst_busy", 32'(sched_busy), 32'd0);
    reset = 1'b0;
    tick();

    // Single request: pending next edge, interrupt the edge after.
    sb.push_back(5);
    pulse(32'h1 << 5);
    check("single_pba_set", pba_pending, 32'h0000_0020);
    check("single_irq_latency", 32'(bus.msix_interrupt), 32'd0);
    expect_irq("single", 1);
    check("single_busy", 32'(sched_busy), 32'd1);
    tick();
    do_ack("single");
    check("single_pba_clr", pba_pending, 32'd0);
    check("single_busy_done", 32'(sched_busy), 32'd1);
    tick();
    check("single_busy_idle", 32'(sched_busy), 32'd0);

    // rr_ptr=6 after vector 5, so 7 and 30 go before 3; afterwards rr_ptr=4.
    sb.push_back(7);
    sb.push_back(30);
    sb.push_back(3);
    pulse((32'h1 << 3) | (32'h1 << 7) | (32'h1 << 30));
    for (int k = 0; k < 3; k++) begin
      expect_irq("rr", 4);
      tick();
      do_ack("rr");
    end
    check("rr_pba_empty", pba_pending, 32'd0);

    // rr_ptr=4: nothing at or above it, so the search wraps and 1 precedes 3.
    sb.push_back(1);
    sb.push_back(3);
    pulse((32'h1 << 3) | (32'h1 << 1));
    for (int k = 0; k < 2; k++) begin
      expect_irq("rr_wrap", 4);
      do_ack("rr_wrap");
    end

    // Vector 31 from rr_ptr=4, then its ack wraps rr_ptr to 0 and 0 follows.
    sb.push_back(31);
    sb.push_back(0);
    pulse((32'h1 << 31) | 32'h1);
    for (int k = 0; k < 2; k++) begin
      expect_irq("top_wrap", 4);
      do_ack("top_wrap");
    end

    // Per-vector mask: pending visible, no delivery until unmasked.
    vec_mask = 32'h1 << 9;
    pulse(32'h1 << 9);
    check("mask_pba", pba_pending, 32'h0000_0200);
    quiet("mask", 20);
    sb.push_back(9);
    vec_mask = '0;
    expect_irq("unmask", 2);
    do_ack("unmask");

    // Function mask blocks all grants.
    msix_function_mask = 1'b1;
    pulse(32'h1 << 12);
    quiet("fmask", 10);
    check("fmask_pba", pba_pending, 32'h0000_1000);
    msix_function_mask = 1'b0;
    sb.push_back(12);
    expect_irq("fmask_rel", 3);
    do_ack("fmask_rel");

    // Disable during WAIT_ACK drops the interrupt and clears the PBA.
    sb.push_back(2);
    pulse(32'h1 << 2);
    expect_irq("dis", 3);
    pulse(32'h1 << 6);
    check("dis_pba_before", pba_pending, 32'h0000_0044);
    msix_enable = 1'b0;
    tick();
    check("dis_irq", 32'(bus.msix_interrupt), 32'd0);
    check("dis_pba", pba_pending, 32'd0);
    check("dis_busy", 32'(sched_busy), 32'd0);
    pulse(32'h1 << 8);
    check("dis_req_dropped", pba_pending, 32'd0);
    msix_enable = 1'b1;
    quiet("reenable", 5);

    // Set wins over clear when the same vector requests at its own ack edge.
    sb.push_back(4);
    pulse(32'h1 << 4);
    expect_irq("setwin", 3);
    vec_req                = 32'h1 << 4;
    bus.msix_interrupt_ack = 1'b1;
    tick();
    vec_req                = '0;
    bus.msix_interrupt_ack = 1'b0;
    check("setwin_irq_drop", 32'(bus.msix_interrupt), 32'd0);
    check("setwin_pba", pba_pending, 32'h0000_0010);
    sb.push_back(4);
    expect_irq("setwin_reissue", 4);
    do_ack("setwin_reissue");
    check("setwin_pba_clr", pba_pending, 32'd0);

    // Ack while no interrupt is outstanding is ignored.
    tick();
    tick();
    bus.msix_interrupt_ack = 1'b1;
    tick();
    bus.msix_interrupt_ack = 1'b0;
    check("stray_ack_busy", 32'(sched_busy), 32'd0);
    check("stray_ack_irq", 32'(bus.msix_interrupt), 32'd0);

    // Asynchronous reset mid-handshake, observed before the next rising edge.
    sb.push_back(10);
    pulse(32'h1 << 10);
    expect_irq("arst", 3);
    #2 reset = 1'b1;
    #1;
    check("arst_irq", 32'(bus.msix_interrupt), 32'd0);
    check("arst_vec", 32'(bus.msix_vector), 32'd0);
    check("arst_pba", pba_pending, 32'd0);
    check("arst_busy", 32'(sched_busy), 32'd0);
    tick();
    reset = 1'b0;
    tick();

`ifdef MSIX_SCHED_TIMEOUT_EN
    begin
      int hi;
      sb.push_back(11);
      pulse(32'h1 << 11);
      expect_irq("tmo", 3);
      hi = 1;
      while (bus.msix_interrupt && hi < 40) begin
        tick();
        if (bus.msix_interrupt) hi++;
      end
      check("tmo_cycles", 32'(hi), 32'(AckTo));
      check("tmo_err", 32'(timeout_err), 32'd1);
      check("tmo_pba_kept", pba_pending, 32'h0000_0800);
    end
`endif

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
